alu_sequencer: RTL

- Sequential front-end for the team's 16-bit combinational ALU (operands a/b, carry-in c, 3-bit op; result w, zero flag, negative flag).
- Accepts commands over a valid/ready handshake and drives registered, stable operands into the ALU.
- Holds them for a programmable settle time, then captures the result and flags into an accumulator.
- Returns a result beat over a second valid/ready handshake.

---
 rtl/alu_sequencer_pkg.sv | 18 +
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: command kinds, FSM states and the
// default datapath width.
package alu_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] KIND_EXEC  = 2'b00;
  localparam logic [1:0] KIND_LOAD  = 2'b01;
  localparam logic [1:0] KIND_CLEAR = 2'b10;
  localparam logic [1:0] KIND_CMP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Sequential front-end for an external combinational ALU: registers operands,
// holds them SETTLE cycles, captures result/flags and returns a result beat.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic             cmd_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_c,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both 1. cmd_ready depends only on state and rst; res_* are held stable
  // while res_valid=1 and res_ready=0.

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_cmp_q, is_cmp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_c_q, alu_c_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_zero_q, res_zero_d;
  logic             res_neg_q, res_neg_d;
  logic             res_valid_q, res_valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_cmp_d    = is_cmp_q;
    acc_d       = acc_q;
    alu_b_d     = alu_b_q;
    alu_c_d     = alu_c_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
    res_valid_d = res_valid_q;
    cmd_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && cmd_ready) begin
          case (cmd_kind)
            KIND_LOAD:  acc_d = cmd_operand;
            KIND_CLEAR: acc_d = '0;
            default: begin
              alu_b_d  = cmd_operand;
              alu_c_d  = cmd_cin;
              alu_op_d = cmd_op;
              is_cmp_d = (cmd_kind == KIND_CMP);
              cnt_d    = SETTLE_M1;
              state_d  = ST_DRIVE;
            end
          endcase
        end
      end
      ST_DRIVE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_data_d  = alu_w;
          res_zero_d  = alu_zero;
          res_neg_d   = alu_neg;
          res_valid_d = 1'b1;
          if (!is_cmp_q) acc_d = alu_w;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      is_cmp_q    <= 1'b0;
      acc_q       <= '0;
      alu_b_q     <= '0;
      alu_c_q     <= 1'b0;
      alu_op_q    <= 3'd0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_cmp_q    <= is_cmp_d;
      acc_q       <= acc_d;
      alu_b_q     <= alu_b_d;
      alu_c_q     <= alu_c_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign acc       = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_neg   = res_neg_q;
  assign res_valid = res_valid_q;
  assign dbg_state = state_q;

endmodule
